// File: rtl/motor_drive.sv
// H-bridge driver stage: maps a 2-bit motor command onto two PWM pins with a soft-start
// duty ramp and a coast dead-time on every forward/backward reversal.
module motor_drive #(
  parameter int unsigned PWM_PERIOD = 1000,
  parameter int unsigned DUTY_FWD   = 600,
  parameter int unsigned DUTY_BACK  = 500,
  parameter int unsigned RAMP_STEP  = 50,
  parameter int unsigned DEAD_TIME  = 20000
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic [1:0] motor,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic       at_speed
);

  localparam int unsigned CW = 20;
  localparam int unsigned DW = 21;
  localparam int unsigned TW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME + 1) : 1;

  localparam logic [CW-1:0] PeriodLast = CW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] DutyFwdW   = DW'(DUTY_FWD);
  localparam logic [DW-1:0] DutyBackW  = DW'(DUTY_BACK);
  localparam logic [DW-1:0] StepW      = DW'(RAMP_STEP);
  localparam logic [TW-1:0] DeadW      = TW'(DEAD_TIME);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRunFwd  = 3'd1,
    StRunBack = 3'd2,
    StDead    = 3'd3,
    StBrake   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cmd_q;
  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [TW-1:0] dead_cnt_q, dead_cnt_d;
  logic          pwm_a_q, pwm_a_d;
  logic          pwm_b_q, pwm_b_d;
  logic          at_speed_q, at_speed_d;

  logic          wrap;
  logic          running;
  logic          pwm_on;
  logic [DW-1:0] target;
  logic [DW-1:0] ramped;
  logic [DW-1:0] duty_ramp;

  always_comb begin
    wrap         = (period_cnt_q == PeriodLast);
    period_cnt_d = wrap ? '0 : period_cnt_q + CW'(1);
    running      = (state_q == StRunFwd) || (state_q == StRunBack);
    target       = (state_q == StRunBack) ? DutyBackW : DutyFwdW;
    ramped       = duty_q + StepW;
    duty_ramp    = (ramped > target) ? target : ramped;
    pwm_on       = ({1'b0, period_cnt_q} < duty_q);
  end

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      StIdle: begin
        case (cmd_q)
          2'b01:   state_d = StRunFwd;
          2'b10:   state_d = StRunBack;
          2'b11:   state_d = StBrake;
          default: state_d = StIdle;
        endcase
      end
      StRunFwd: begin
        case (cmd_q)
          2'b00: state_d = StIdle;
          2'b11: state_d = StBrake;
          2'b10: begin
            state_d    = StDead;
            dead_cnt_d = DeadW;
          end
          default: state_d = StRunFwd;
        endcase
      end
      StRunBack: begin
        case (cmd_q)
          2'b00: state_d = StIdle;
          2'b11: state_d = StBrake;
          2'b01: begin
            state_d    = StDead;
            dead_cnt_d = DeadW;
          end
          default: state_d = StRunBack;
        endcase
      end
      StDead: begin
        dead_cnt_d = dead_cnt_q - TW'(1);
        if (cmd_q == 2'b00) begin
          state_d = StIdle;
        end else if (cmd_q == 2'b11) begin
          state_d = StBrake;
        end else if (dead_cnt_q <= TW'(1)) begin
          // Timer expired: resume whichever direction is commanded now.
          state_d = (cmd_q == 2'b01) ? StRunFwd : StRunBack;
        end
      end
      StBrake: begin
        case (cmd_q)
          2'b00:   state_d = StIdle;
          2'b01:   state_d = StRunFwd;
          2'b10:   state_d = StRunBack;
          default: state_d = StBrake;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // A state change always restarts the duty at zero, even on a wrap cycle.
  always_comb begin
    duty_d = duty_q;
    if (state_d != state_q) begin
      duty_d = '0;
    end else if (running && wrap) begin
      duty_d = duty_ramp;
    end
  end

  always_comb begin
    pwm_a_d    = ((state_q == StRunFwd) && pwm_on) || (state_q == StBrake);
    pwm_b_d    = ((state_q == StRunBack) && pwm_on) || (state_q == StBrake);
    at_speed_d = ((state_q == StRunFwd) && (duty_q == DutyFwdW)) ||
                 ((state_q == StRunBack) && (duty_q == DutyBackW));
  end

  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cmd_q        <= 2'b00;
      period_cnt_q <= '0;
      duty_q       <= '0;
      dead_cnt_q   <= '0;
      pwm_a_q      <= 1'b0;
      pwm_b_q      <= 1'b0;
      at_speed_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= motor;
      period_cnt_q <= period_cnt_d;
      duty_q       <= duty_d;
      dead_cnt_q   <= dead_cnt_d;
      pwm_a_q      <= pwm_a_d;
      pwm_b_q      <= pwm_b_d;
      at_speed_q   <= at_speed_d;
    end
  end

  assign pwm_a    = pwm_a_q;
  assign pwm_b    = pwm_b_q;
  assign at_speed = at_speed_q;

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive: ramp, reversal dead-time, brake paths, bounce and reset.
module tb_motor_drive;

  logic       clkus;
  logic       rst;
  logic [1:0] motor;
  logic       pwm_a;
  logic       pwm_b;
  logic       at_speed;

  int n_checks;
  int n_errors;
  int k;
  int na, nb, ns;

  motor_drive #(
    .PWM_PERIOD(10),
    .DUTY_FWD  (6),
    .DUTY_BACK (5),
    .RAMP_STEP (2),
    .DEAD_TIME (5)
  ) dut (
    .clkus   (clkus),
    .rst     (rst),
    .motor   (motor),
    .pwm_a   (pwm_a),
    .pwm_b   (pwm_b),
    .at_speed(at_speed)
  );

  initial clkus = 1'b0;
  always #5 clkus = ~clkus;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Step clock edges until edge index kend, sampling after each edge and counting highs.
  task automatic run_to(input int kend, output int ca, output int cb, output int cs);
    ca = 0;
    cb = 0;
    cs = 0;
    while (k < kend) begin
      @(posedge clkus);
      #2;
      k++;
      ca += int'(pwm_a);
      cb += int'(pwm_b);
      cs += int'(at_speed);
    end
  endtask

  function automatic int pins();
    return int'({pwm_a, pwm_b});
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    k        = 0;
    rst      = 1'b1;
    motor    = 2'b01;
    #2;
    check("reset_pins", pins(), 0);
    check("reset_at_speed", int'(at_speed), 0);
    #1 rst = 1'b0;

    // Forward soft start: 0, 2, 4, 6 high cycles per period
    run_to(10, na, nb, ns);
    check("fwd_p0", na, 0);
    run_to(20, na, nb, ns);
    check("fwd_p1", na, 2);
    run_to(30, na, nb, ns);
    check("fwd_p2", na, 4);
    check("fwd_p2_at_speed", ns, 0);
    run_to(40, na, nb, ns);
    check("fwd_p3", na, 6);
    check("fwd_p3_at_speed", ns, 10);
    check("fwd_pwm_b", nb, 0);
    run_to(50, na, nb, ns);
    check("fwd_steady", na, 6);

    // Reversal fwd->back with 5-cycle coast
    motor = 2'b10;
    run_to(52, na, nb, ns);
    check("rev_last_fwd", pins(), 2);
    run_to(57, na, nb, ns);
    check("rev_coast", na + nb, 0);
    run_to(60, na, nb, ns);
    run_to(70, na, nb, ns);
    check("back_p1", nb, 2);
    check("back_p1_a", na, 0);
    run_to(80, na, nb, ns);
    check("back_p2", nb, 4);
    check("back_p2_at_speed", ns, 0);
    run_to(90, na, nb, ns);
    check("back_p3_sat", nb, 5);
    check("back_p3_at_speed", ns, 10);

    // Brake from RUN_BACK, then stop
    motor = 2'b11;
    run_to(92, na, nb, ns);
    check("brake_pre_pins", pins(), 1);
    check("brake_pre_at_speed", int'(at_speed), 1);
    run_to(93, na, nb, ns);
    check("brake_pins", pins(), 3);
    check("brake_at_speed", int'(at_speed), 0);
    run_to(95, na, nb, ns);
    motor = 2'b00;
    run_to(97, na, nb, ns);
    check("stop_pre_pins", pins(), 3);
    run_to(98, na, nb, ns);
    check("stop_pins", pins(), 0);

    // Brake while coasting, then forward with no dead time
    run_to(100, na, nb, ns);
    motor = 2'b01;
    run_to(105, na, nb, ns);
    motor = 2'b10;
    run_to(108, na, nb, ns);
    motor = 2'b11;
    run_to(110, na, nb, ns);
    check("dead_brake_pre", pins(), 0);
    run_to(111, na, nb, ns);
    check("dead_brake", pins(), 3);
    run_to(113, na, nb, ns);
    motor = 2'b01;
    run_to(115, na, nb, ns);
    check("brake_fwd_pre", pins(), 3);
    run_to(116, na, nb, ns);
    check("brake_fwd", pins(), 0);
    run_to(120, na, nb, ns);
    run_to(130, na, nb, ns);
    check("bf_p1", na, 2);
    run_to(140, na, nb, ns);
    check("bf_p2", na, 4);
    run_to(150, na, nb, ns);
    check("bf_p3", na, 6);
    check("bf_p3_at_speed", ns, 10);

    // Bounce: back to forward during coast still waits out the timer
    motor = 2'b10;
    run_to(152, na, nb, ns);
    check("bounce_last_fwd", pins(), 2);
    motor = 2'b01;
    run_to(157, na, nb, ns);
    check("bounce_coast", na + nb, 0);
    run_to(160, na, nb, ns);
    run_to(170, na, nb, ns);
    check("bounce_p1", na, 2);
    check("bounce_p1_b", nb, 0);
    run_to(180, na, nb, ns);
    check("bounce_p2", na, 4);
    run_to(190, na, nb, ns);
    check("bounce_p3", na, 6);

    // Asynchronous reset mid-pulse
    run_to(191, na, nb, ns);
    check("pre_rst_pwm_a", int'(pwm_a), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_pins", pins(), 0);
    check("async_rst_at_speed", int'(at_speed), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
